// File: rtl/cdb_slot_scheduler.sv
// cdb_slot_scheduler
//   Issues instructions from up to NUM_UNITS queues and drives a single
//   registered Common Data Bus.
//   A shift register of result slots (slot k = the bus owner k cycles from
//   now) reserves the bus cycle in which each unit's result will appear.
//   An issue is granted only if that cycle is still free, so results never
//   collide. Units with equal latency compete for the same slot under
//   round-robin priority.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   ready               queue i holds a ready instruction
//   unit_busy           execution unit i cannot accept an instruction
//   flush               mispredict flush (cancels all reservations)
//   issue               combinational issue grant per queue
//   unit_valid/tag/data/branch/branch_taken
//                       per-unit result presentation (packed)
//   cdb_*               registered CDB result, plus the unit that drove it
//   slot_busy           reservation occupancy (debug)
//   proto_err           sticky flag: missing or unexpected unit result
module cdb_slot_scheduler #(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned MAX_LAT   = 8,
  parameter logic [4*NUM_UNITS-1:0] UNIT_LAT = 16'h2841,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned DATA_W    = 32,
  localparam int unsigned OWN_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_UNITS-1:0]        ready,
  input  logic [NUM_UNITS-1:0]        unit_busy,
  input  logic                        flush,
  output logic [NUM_UNITS-1:0]        issue,
  input  logic [NUM_UNITS-1:0]        unit_valid,
  input  logic [NUM_UNITS*TAG_W-1:0]  unit_tag,
  input  logic [NUM_UNITS*DATA_W-1:0] unit_data,
  input  logic [NUM_UNITS-1:0]        unit_branch,
  input  logic [NUM_UNITS-1:0]        unit_branch_taken,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic                        cdb_branch,
  output logic                        cdb_branch_taken,
  output logic [OWN_W-1:0]            cdb_owner,
  output logic [MAX_LAT-1:0]          slot_busy,
  output logic                        proto_err
);

  logic [MAX_LAT-1:0]   slot_valid;
  logic [OWN_W-1:0]     slot_owner [MAX_LAT];
  logic [MAX_LAT-1:0]   nxt_valid;
  logic [OWN_W-1:0]     nxt_owner  [MAX_LAT];
  logic [OWN_W-1:0]     rr_ptr;
  logic [OWN_W-1:0]     rr_nxt;
  logic                 rr_hit;
  logic [NUM_UNITS-1:0] cand;
  logic [NUM_UNITS-1:0] grant;
  logic [NUM_UNITS-1:0] own_mask;
  logic                 sel_valid;
  logic [TAG_W-1:0]     sel_tag;
  logic [DATA_W-1:0]    sel_data;
  logic                 sel_br;
  logic                 sel_tk;
  logic                 err_now;

  function automatic int unsigned lat_of(input int unsigned u);
    logic [4*NUM_UNITS-1:0] v;
    v = UNIT_LAT >> (4 * u);
    return 32'(v[3:0]);
  endfunction

  function automatic logic slot_bit(input logic [MAX_LAT-1:0] v, input int unsigned k);
    logic [MAX_LAT-1:0] s;
    s = v >> k;
    return s[0];
  endfunction

  function automatic logic unit_bit(input logic [NUM_UNITS-1:0] v, input int unsigned k);
    logic [NUM_UNITS-1:0] s;
    s = v >> k;
    return s[0];
  endfunction

  // Distance of unit u from the round-robin pointer (0 = highest priority).
  function automatic int unsigned rot_pos(input int unsigned u, input logic [OWN_W-1:0] rr);
    return (u + NUM_UNITS - 32'(rr)) % NUM_UNITS;
  endfunction

  // Slot L is read before the shift; it becomes slot L-1 at the edge, which
  // is where the grant is written. A slot vacated by the shift is therefore
  // bookable in the same cycle.
  function automatic logic slot_free(input logic [MAX_LAT-1:0] v, input int unsigned l);
    return (l >= MAX_LAT) || !slot_bit(v, l);
  endfunction

  always_comb begin
    cand = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++)
      cand[i] = ready[i] && !unit_busy[i] && !flush && !rst && slot_free(slot_valid, lat_of(i));
    // Among candidates of equal latency only the one nearest rr_ptr survives.
    grant = cand;
    for (int unsigned i = 0; i < NUM_UNITS; i++)
      for (int unsigned j = 0; j < NUM_UNITS; j++)
        if (j != i && cand[j] && lat_of(j) == lat_of(i) &&
            rot_pos(j, rr_ptr) < rot_pos(i, rr_ptr))
          grant[i] = 1'b0;
  end

  assign issue = grant;

  always_comb begin
    rr_hit = 1'b0;
    rr_nxt = rr_ptr;
    for (int unsigned off = 0; off < NUM_UNITS; off++)
      if (!rr_hit && unit_bit(grant, (32'(rr_ptr) + off) % NUM_UNITS)) begin
        rr_hit = 1'b1;
        rr_nxt = OWN_W'((32'(rr_ptr) + off + 1) % NUM_UNITS);
      end
  end

  // Shifted reservation array with this cycle's grants written in.
  always_comb begin
    nxt_valid = slot_valid >> 1;
    for (int unsigned k = 0; k < MAX_LAT; k++)
      nxt_owner[k] = '0;
    for (int unsigned k = 0; k + 1 < MAX_LAT; k++)
      nxt_owner[k] = slot_owner[k+1];
    for (int unsigned k = 0; k < MAX_LAT; k++)
      for (int unsigned i = 0; i < NUM_UNITS; i++)
        if (grant[i] && lat_of(i) == k + 1) begin
          nxt_valid[k] = 1'b1;
          nxt_owner[k] = OWN_W'(i);
        end
  end

  // Result of the unit that owns the bus this cycle.
  always_comb begin
    own_mask  = '0;
    sel_valid = 1'b0;
    sel_tag   = '0;
    sel_data  = '0;
    sel_br    = 1'b0;
    sel_tk    = 1'b0;
    for (int unsigned i = 0; i < NUM_UNITS; i++)
      if (slot_valid[0] && slot_owner[0] == OWN_W'(i)) begin
        own_mask[i] = 1'b1;
        sel_valid   = unit_valid[i];
        sel_tag     = unit_tag[i*TAG_W +: TAG_W];
        sel_data    = unit_data[i*DATA_W +: DATA_W];
        sel_br      = unit_branch[i];
        sel_tk      = unit_branch_taken[i];
      end
  end

  assign err_now = !flush && ((slot_valid[0] && !sel_valid) || (|(unit_valid & ~own_mask)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= '0;
      for (int unsigned k = 0; k < MAX_LAT; k++)
        slot_owner[k] <= '0;
      rr_ptr           <= '0;
      cdb_valid        <= 1'b0;
      cdb_tag          <= '0;
      cdb_data         <= '0;
      cdb_branch       <= 1'b0;
      cdb_branch_taken <= 1'b0;
      cdb_owner        <= '0;
      proto_err        <= 1'b0;
    end else begin
      if (rr_hit)
        rr_ptr <= rr_nxt;
      slot_valid <= flush ? '0 : nxt_valid;
      slot_owner <= nxt_owner;
      cdb_valid  <= !flush && sel_valid;
      if (!flush && sel_valid) begin
        cdb_tag          <= sel_tag;
        cdb_data         <= sel_data;
        cdb_branch       <= sel_br;
        cdb_branch_taken <= sel_tk;
        cdb_owner        <= slot_owner[0];
      end
      if (err_now)
        proto_err <= 1'b1;
    end
  end

  assign slot_busy = slot_valid;

endmodule

// File: tb/tb_cdb_slot_scheduler.sv
module tb_cdb_slot_scheduler;
  localparam int TW = 6;
  localparam int DW = 32;
  localparam logic [15:0] LATS = 16'h2841;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] ready = '0, unit_busy = '0, unit_valid = '0;
  logic [3:0] unit_branch = '0, unit_branch_taken = '0;
  logic flush = 1'b0;
  logic [4*TW-1:0] unit_tag = '0;
  logic [4*DW-1:0] unit_data = '0;
  logic [3:0] issue;
  logic cdb_valid, cdb_branch, cdb_branch_taken, proto_err;
  logic [TW-1:0] cdb_tag;
  logic [DW-1:0] cdb_data;
  logic [1:0] cdb_owner;
  logic [7:0] slot_busy;

  // Second instance: all latencies 1, for round-robin rotation.
  logic [3:0] ready2 = '0, uv2 = '0, zero4 = '0;
  logic zero1 = 1'b0;
  logic [4*TW-1:0] tag2 = '0;
  logic [4*DW-1:0] data2 = '0;
  logic [3:0] issue2;
  logic cdb2_valid, cdb2_br, cdb2_tk, proto2;
  logic [TW-1:0] cdb2_tag;
  logic [DW-1:0] cdb2_data;
  logic [1:0] cdb2_own;
  logic [7:0] sb2;

  always #5 clk = ~clk;

  cdb_slot_scheduler #(.NUM_UNITS(4), .MAX_LAT(8), .UNIT_LAT(LATS), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .ready(ready), .unit_busy(unit_busy), .flush(flush), .issue(issue),
    .unit_valid(unit_valid), .unit_tag(unit_tag), .unit_data(unit_data),
    .unit_branch(unit_branch), .unit_branch_taken(unit_branch_taken),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_branch(cdb_branch),
    .cdb_branch_taken(cdb_branch_taken), .cdb_owner(cdb_owner), .slot_busy(slot_busy),
    .proto_err(proto_err));

  cdb_slot_scheduler #(.NUM_UNITS(4), .MAX_LAT(8), .UNIT_LAT(16'h1111), .TAG_W(TW), .DATA_W(DW)) dut2 (
    .clk(clk), .rst(rst), .ready(ready2), .unit_busy(zero4), .flush(zero1), .issue(issue2),
    .unit_valid(uv2), .unit_tag(tag2), .unit_data(data2),
    .unit_branch(zero4), .unit_branch_taken(zero4),
    .cdb_valid(cdb2_valid), .cdb_tag(cdb2_tag), .cdb_data(cdb2_data), .cdb_branch(cdb2_br),
    .cdb_branch_taken(cdb2_tk), .cdb_owner(cdb2_own), .slot_busy(sb2), .proto_err(proto2));

  // Reference model: a calendar of absolute bus cycles, each holding the
  // unit that reserved it (-1 = free).
  int book [16];
  int rr, cyc;
  logic m_valid, m_br, m_tk, m_err;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;
  logic [1:0] m_own;
  logic tag_fix_en = 1'b0;
  int n_checks = 0, n_errors = 0;

  function automatic int lat(input int i);
    return int'((LATS >> (4 * i)) & 16'hF);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) book[k] = -1;
    rr = 0;
    m_valid = 1'b0; m_br = 1'b0; m_tk = 1'b0; m_err = 1'b0;
    m_tag = '0; m_data = '0; m_own = '0;
  endtask

  // One cycle; entered and left 1 time unit after a rising edge.
  task automatic step(input logic [3:0] rdy, input logic [3:0] bsy, input logic fl,
                      input logic [3:0] hold, input logic [3:0] rogue);
    int o, u, first;
    logic [3:0] uv, exp_iss, own_mask;
    logic [7:0] exp_sb;
    o = book[cyc % 16];
    uv = rogue;
    own_mask = '0;
    if (o >= 0) begin
      own_mask[o] = 1'b1;
      uv[o] = !hold[o];
    end
    for (int i = 0; i < 4; i++) begin
      unit_tag[i*TW +: TW] = TW'($urandom);
      unit_data[i*DW +: DW] = $urandom;
    end
    if (tag_fix_en) begin
      unit_tag[TW-1:0] = 6'd5;
      unit_data[DW-1:0] = 32'h11;
    end
    unit_branch = 4'($urandom);
    unit_branch_taken = 4'($urandom);
    ready = rdy; unit_busy = bsy; flush = fl; unit_valid = uv;

    exp_iss = '0;
    first = -1;
    for (int n = 0; n < 4; n++) begin
      u = (rr + n) % 4;
      if (rdy[u] && !bsy[u] && !fl && book[(cyc + lat(u)) % 16] < 0) begin
        exp_iss[u] = 1'b1;
        book[(cyc + lat(u)) % 16] = u;
        if (first < 0) first = u;
      end
    end
    if (first >= 0) rr = (first + 1) % 4;
    #1;
    chk("issue", 64'(issue), 64'(exp_iss));

    if (!fl && o >= 0 && uv[o]) begin
      m_valid = 1'b1;
      m_tag = unit_tag[o*TW +: TW];
      m_data = unit_data[o*DW +: DW];
      m_br = unit_branch[o];
      m_tk = unit_branch_taken[o];
      m_own = 2'(o);
    end else
      m_valid = 1'b0;
    if (!fl && ((o >= 0 && !uv[o]) || (uv & ~own_mask) != 4'b0)) m_err = 1'b1;
    book[cyc % 16] = -1;
    if (fl) for (int k = 0; k < 16; k++) book[k] = -1;
    cyc++;

    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) exp_sb[k] = book[(cyc + k) % 16] >= 0;
    chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    chk("cdb_tag", 64'(cdb_tag), 64'(m_tag));
    chk("cdb_data", 64'(cdb_data), 64'(m_data));
    chk("cdb_branch", 64'(cdb_branch), 64'(m_br));
    chk("cdb_taken", 64'(cdb_branch_taken), 64'(m_tk));
    chk("cdb_owner", 64'(cdb_owner), 64'(m_own));
    chk("proto_err", 64'(proto_err), 64'(m_err));
    chk("slot_busy", 64'(slot_busy), 64'(exp_sb));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ready = '1;
    #1;
    chk("rst_issue", 64'(issue), 64'd0);
    chk("rst_slot_busy", 64'(slot_busy), 64'd0);
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("rst_proto", 64'(proto_err), 64'd0);
    chk("rst_cdb_tag", 64'(cdb_tag), 64'd0);
    rst = 1'b0;
    ready = '0; unit_valid = '0; flush = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] last, exp_rr;
    cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("init_owner", 64'(cdb_owner), 64'd0);
    chk("init_slot_busy", 64'(slot_busy), 64'd0);
    chk("init_proto", 64'(proto_err), 64'd0);
    rst = 1'b0;

    // Round-robin on the all-latency-1 instance.
    last = '0;
    for (int k = 0; k < 5; k++) begin
      ready2 = '1;
      uv2 = last;
      #1;
      exp_rr = 4'b0001 << (k % 4);
      chk("rr_issue", 64'(issue2), 64'(exp_rr));
      last = issue2;
      @(posedge clk);
      #1;
    end
    ready2 = '0;
    uv2 = last;
    @(posedge clk);
    #1;
    uv2 = '0;
    chk("rr_proto", 64'(proto2), 64'd0);

    // Multi-issue of all four distinct latencies.
    step(4'b1111, '0, 1'b0, '0, '0);
    idle(10);

    // Slot conflict: mult books the cycle int would need.
    step(4'b0010, '0, 1'b0, '0, '0);
    idle(2);
    step(4'b0001, '0, 1'b0, '0, '0);
    step(4'b0001, '0, 1'b0, '0, '0);
    idle(5);
    chk("conflict_proto", 64'(proto_err), 64'd0);

    // Busy divider, then flush with three reservations outstanding.
    step(4'b0100, 4'b0100, 1'b0, '0, '0);
    step(4'b1110, '0, 1'b0, '0, '0);
    step(4'b1111, '0, 1'b1, '0, '0);
    chk("flush_slot_busy", 64'(slot_busy), 64'd0);
    idle(9);

    // Reset mid-run with reservations outstanding.
    step(4'b1111, '0, 1'b0, '0, '0);
    do_reset();
    step(4'b0001, '0, 1'b0, '0, '0);
    tag_fix_en = 1'b1;
    step('0, '0, 1'b0, '0, '0);
    tag_fix_en = 1'b0;
    chk("rst_then_tag", 64'(cdb_tag), 64'd5);
    chk("rst_then_data", 64'(cdb_data), 64'h11);
    idle(2);

    // Random legal traffic.
    for (int n = 0; n < 300; n++)
      step(4'($urandom), 4'($urandom) & 4'($urandom), $urandom_range(0, 31) == 0, '0, '0);
    idle(9);

    // Missing result, then a rogue result.
    step(4'b0001, '0, 1'b0, '0, '0);
    step('0, '0, 1'b0, 4'b0001, '0);
    chk("missing_proto", 64'(proto_err), 64'd1);
    idle(3);
    chk("proto_sticky", 64'(proto_err), 64'd1);
    do_reset();
    step('0, '0, 1'b0, '0, 4'b0010);
    chk("rogue_proto", 64'(proto_err), 64'd1);
    chk("rogue_cdb", 64'(cdb_valid), 64'd0);

    // Random traffic with occasional protocol faults.
    do_reset();
    for (int n = 0; n < 150; n++)
      step(4'($urandom), 4'($urandom) & 4'($urandom), $urandom_range(0, 31) == 0,
           ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0,
           ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
